mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data load-store) arbiter in
// front of a single shared memory port. One access is outstanding at a time;
// data normally wins over fetch.
// Optional build macro MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard:
// after STARVE_MAX consecutive data grants with a fetch waiting, the fetch is
// granted ahead of data.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_I_ACC = 2'd1;
  localparam logic [1:0] ST_D_ACC = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        fetch_forced;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT = STARVE_MAX[3:0];

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign fetch_forced = i_req && (starve_cnt_q == STARVE_LIMIT);

  // Count data grants that overtake a waiting fetch; any fetch grant or an idle cycle without a fetch request starts over.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (i_gnt || ((state_q == ST_IDLE) && !i_req)) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && i_req) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_max;

  assign fetch_forced      = 1'b0;
  assign unused_starve_max = (STARVE_MAX != 0);
`endif

  // Grants are only possible in IDLE; data beats fetch unless the guard forces the fetch through.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (state_q == ST_IDLE) begin
      if (d_req && !fetch_forced) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Capture the granted request, hold it on the memory port until ack, then return data with a one-cycle valid pulse.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (d_gnt) begin
          we_d    = d_we;
          be_d    = d_be;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = ST_D_ACC;
        end else if (i_gnt) begin
          we_d    = 1'b0;
          be_d    = 4'hF;
          addr_d  = i_addr;
          state_d = ST_I_ACC;
        end
      end
      ST_I_ACC: begin
        if (mem_ack) begin
          i_rdata_d  = mem_rdata;
          i_rvalid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_D_ACC: begin
        if (mem_ack) begin
          d_rdata_d  = mem_rdata;
          d_rvalid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured request and response registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A transaction-level model
// of who owns the memory port is checked against the DUT on every falling
// edge; directed sequences add literal expectations for the key scenarios.
// Honours MEM_ARB_STARVE_GUARD_EN to match the DUT build.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int nVectors = 0;
  int nMiscompares = 0;

  // responder configuration
  int          ackDelay = 0;
  bit          ackEnable = 1'b1;
  logic [31:0] rdataVal = 32'd0;
  int          waitCnt = 0;

  // model state: owner 0 = nobody, 1 = fetch, 2 = data
  int          mOwner = 0;
  logic        mWe = 1'b0;
  logic [3:0]  mBe = 4'd0;
  logic [31:0] mAddr = 32'd0;
  logic [31:0] mWdata = 32'd0;
  logic        mIRv = 1'b0;
  logic        mDRv = 1'b0;
  logic [31:0] mIData = 32'd0;
  logic [31:0] mDData = 32'd0;
  logic        mDLoad = 1'b0;
  int          mStreak = 0;
  logic        expIg, expDg, mIdle, mForced;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dWe, input logic [3:0] dBe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata);
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_be    = dBe;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks after ackDelay wait cycles of mem_req, or never when disabled.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mem_req) begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end else if (!ackEnable) begin
        mem_ack = 1'b0;
      end else if (waitCnt >= ackDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdataVal;
        waitCnt   = 0;
      end else begin
        mem_ack = 1'b0;
        waitCnt++;
      end
    end
  end

  // Compare process: outputs against the ownership model every cycle, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
      checkOutput("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
      checkOutput("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      mOwner  = 0;
      mIRv    = 1'b0;
      mDRv    = 1'b0;
      mStreak = 0;
    end else begin
      mIdle   = (mOwner == 0);
      mForced = GUARD && i_req && (mStreak >= STARVE_MAX);
      expDg   = mIdle && d_req && !mForced;
      expIg   = mIdle && i_req && !expDg;
      checkOutput("d_gnt", {31'd0, d_gnt}, {31'd0, expDg});
      checkOutput("i_gnt", {31'd0, i_gnt}, {31'd0, expIg});
      checkOutput("busy", {31'd0, busy}, {31'd0, !mIdle});
      checkOutput("mem_req", {31'd0, mem_req}, {31'd0, !mIdle});
      checkOutput("i_rvalid", {31'd0, i_rvalid}, {31'd0, mIRv});
      checkOutput("d_rvalid", {31'd0, d_rvalid}, {31'd0, mDRv});
      if (mIRv) checkOutput("i_rdata", i_rdata, mIData);
      if (mDRv && mDLoad) checkOutput("d_rdata", d_rdata, mDData);
      if (!mIdle) begin
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, mWe});
        checkOutput("mem_be", {28'd0, mem_be}, {28'd0, mBe});
        checkOutput("mem_addr", mem_addr, mAddr);
        if (mOwner == 2) checkOutput("mem_wdata", mem_wdata, mWdata);
      end
      mIRv = (mOwner == 1) && mem_ack;
      mDRv = (mOwner == 2) && mem_ack;
      if (mIRv) mIData = mem_rdata;
      if (mDRv) begin
        mDData = mem_rdata;
        mDLoad = !mWe;
      end
      if (!mIdle && mem_ack) mOwner = 0;
      if (expDg) begin
        mOwner = 2;
        mWe    = d_we;
        mBe    = d_be;
        mAddr  = d_addr;
        mWdata = d_wdata;
      end else if (expIg) begin
        mOwner = 1;
        mWe    = 1'b0;
        mBe    = 4'hF;
        mAddr  = i_addr;
      end
      if (GUARD) begin
        if (expIg || (mIdle && !i_req)) mStreak = 0;
        else if (expDg && i_req) mStreak++;
      end
    end
  end

  // Directed sequences with literal expectations.
  initial begin
    int dCnt;
    int iCnt;
    int firstI;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick;
    tick;
    #2;
    checkOutput("reset_mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset_i_rdata", i_rdata, 32'd0);
    checkOutput("reset_d_rdata", d_rdata, 32'd0);
    rdataVal = 32'h0000_0013;

    // single fetch, granted in the first cycle after reset release
    tick;
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("fetch_i_gnt_c0", {31'd0, i_gnt}, 32'd1);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("fetch_mem_addr_c1", mem_addr, 32'h0000_1000);
    checkOutput("fetch_mem_be_c1", {28'd0, mem_be}, 32'hF);
    checkOutput("fetch_mem_we_c1", {31'd0, mem_we}, 32'd0);
    tick;
    #2;
    checkOutput("fetch_i_rvalid_c2", {31'd0, i_rvalid}, 32'd1);
    checkOutput("fetch_i_rdata_c2", i_rdata, 32'h0000_0013);
    rdataVal = 32'hCAFE_0001;
    tick;
    #2;
    checkOutput("fetch_i_rvalid_c3", {31'd0, i_rvalid}, 32'd0);

    // simultaneous requests: data first, fetch granted in the d_rvalid cycle
    tick;
    applyStimulus(1'b1, 32'h0000_3000, 1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'd0);
    #2;
    checkOutput("simul_d_gnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("simul_i_gnt", {31'd0, i_gnt}, 32'd0);
    tick;
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("simul_mem_addr", mem_addr, 32'h0000_2004);
    checkOutput("simul_busy_i_gnt", {31'd0, i_gnt}, 32'd0);
    tick;
    #2;
    checkOutput("simul_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("simul_d_rdata", d_rdata, 32'hCAFE_0001);
    checkOutput("simul_i_gnt_late", {31'd0, i_gnt}, 32'd1);
    rdataVal = 32'h1111_0000;
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("simul_fetch_addr", mem_addr, 32'h0000_3000);
    tick;
    #2;
    checkOutput("simul_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    checkOutput("simul_i_rdata", i_rdata, 32'h1111_0000);
    ackDelay = 3;

    // store with 3 wait cycles; a fetch request raised and dropped while busy gets nothing
    tick;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h0000_2008, 32'hDEAD_BEEF);
    #2;
    checkOutput("store_d_gnt", {31'd0, d_gnt}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick;
      applyStimulus(c < 3, 32'h0000_4000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      #2;
      checkOutput("store_wait_mem_req", {31'd0, mem_req}, 32'd1);
      checkOutput("store_wait_wdata", mem_wdata, 32'hDEAD_BEEF);
      checkOutput("store_wait_be", {28'd0, mem_be}, 32'h3);
      checkOutput("store_wait_we", {31'd0, mem_we}, 32'd1);
      checkOutput("store_wait_no_i_gnt", {31'd0, i_gnt}, 32'd0);
    end
    tick;
    #2;
    checkOutput("store_ack_cycle_addr", mem_addr, 32'h0000_2008);
    tick;
    #2;
    checkOutput("store_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("store_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    checkOutput("store_no_i_gnt", {31'd0, i_gnt}, 32'd0);
    ackDelay = 0;
    tick;
    #2;
    checkOutput("store_d_rvalid_once", {31'd0, d_rvalid}, 32'd0);

    // both requesters held high: count grants over 15 back-to-back accesses
    dCnt = 0;
    iCnt = 0;
    firstI = 99;
    for (int c = 0; c < 30; c++) begin
      tick;
      applyStimulus(1'b1, 32'h0000_5000, 1'b1, 1'b0, 4'hF, 32'h0000_6000, 32'd0);
      #2;
      if (i_gnt) begin
        if (firstI == 99) firstI = dCnt;
        iCnt++;
      end
      if (d_gnt) dCnt++;
    end
    checkOutput("held_fetch_grants", iCnt, GUARD ? 32'd3 : 32'd0);
    checkOutput("held_data_grants", dCnt, GUARD ? 32'd12 : 32'd15);
    checkOutput("held_data_before_fetch", firstI, GUARD ? 32'd4 : 32'd99);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick;
    tick;
    ackEnable = 1'b0;

    // reset in the middle of a load that is never acked
    tick;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h0000_2010, 32'd0);
    #2;
    checkOutput("rstmid_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd1);
    tick;
    #2;
    checkOutput("rstmid_no_ack_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_mem_req_now", {31'd0, mem_req}, 32'd0);
    checkOutput("rstmid_busy_now", {31'd0, busy}, 32'd0);
    ackEnable = 1'b1;
    rdataVal = 32'h55AA_55AA;
    tick;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h0000_2014, 32'd0);
    #2;
    checkOutput("rstmid_next_d_gnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("rstmid_no_stale_rv", {31'd0, d_rvalid}, 32'd0);
    tick;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #2;
    checkOutput("rstmid_no_stale_rv2", {31'd0, d_rvalid}, 32'd0);
    checkOutput("rstmid_new_addr", mem_addr, 32'h0000_2014);
    tick;
    #2;
    checkOutput("rstmid_new_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("rstmid_new_rdata", d_rdata, 32'h55AA_55AA);
    tick;
    #2;
    checkOutput("rstmid_rvalid_pulse", {31'd0, d_rvalid}, 32'd0);
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
